// File: rtl/la_ioanalog_muxctrl.sv
// Core-side analog mux sequencer: routes one core channel onto AMUXBUS_A or AMUXBUS_B
// with a break-before-make gap (all switches open) followed by a settle window.
module la_ioanalog_muxctrl #(
  parameter int unsigned N      = 4,
  parameter int unsigned BBM    = 4,
  parameter int unsigned SETTLE = 8,
  localparam int unsigned SW     = $clog2(N),
  localparam int unsigned CntMax = (BBM > SETTLE) ? BBM : SETTLE,
  localparam int unsigned CW     = $clog2(CntMax + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_off,
  input  logic [SW-1:0] req_sel,
  input  logic          req_bus,
  output logic [N-1:0]  en_a,
  output logic [N-1:0]  en_b,
  output logic          settled,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] act_sel,
  output logic          act_bus
);

  typedef enum logic [1:0] {StIdle, StBreak, StSettle, StOn} state_e;

  localparam logic [SW:0] NLim = (SW + 1)'(N);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] tgt_sel_q;
  logic          tgt_bus_q;
  logic          tgt_off_q;
  logic [N-1:0]  en_a_q, en_b_q;
  logic          settled_q, done_q, err_q;
  logic [SW-1:0] act_sel_q;
  logic          act_bus_q;

  logic          accept;
  logic          sel_illegal;
  logic          same_path;
  logic [N-1:0]  tgt_onehot;

  always_comb begin
    req_ready   = (state_q == StIdle) || (state_q == StOn);
    accept      = req_valid && req_ready;
    sel_illegal = !req_off && ({1'b0, req_sel} >= NLim);
    same_path   = (state_q == StOn) && !req_off && (req_sel == act_sel_q) &&
                  (req_bus == act_bus_q);
    tgt_onehot  = N'(1) << tgt_sel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset opens every switch immediately; no break gap is needed with nothing closed.
      state_q   <= StIdle;
      cnt_q     <= '0;
      tgt_sel_q <= '0;
      tgt_bus_q <= 1'b0;
      tgt_off_q <= 1'b0;
      en_a_q    <= '0;
      en_b_q    <= '0;
      settled_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      act_sel_q <= '0;
      act_bus_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle, StOn: begin
          if (accept) begin
            if (sel_illegal) begin
              err_q <= 1'b1;
            end else if (same_path || (req_off && (state_q == StIdle))) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= StBreak;
              cnt_q     <= CW'(BBM - 1);
              en_a_q    <= '0;
              en_b_q    <= '0;
              settled_q <= 1'b0;
              tgt_sel_q <= req_sel;
              tgt_bus_q <= req_bus;
              tgt_off_q <= req_off;
            end
          end
        end
        StBreak: begin
          if (cnt_q == '0) begin
            if (tgt_off_q) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StSettle;
              cnt_q     <= CW'(SETTLE - 1);
              en_a_q    <= tgt_bus_q ? '0 : tgt_onehot;
              en_b_q    <= tgt_bus_q ? tgt_onehot : '0;
              act_sel_q <= tgt_sel_q;
              act_bus_q <= tgt_bus_q;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q   <= StOn;
            settled_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_a    = en_a_q;
  assign en_b    = en_b_q;
  assign settled = settled_q;
  assign done    = done_q;
  assign err     = err_q;
  assign act_sel = act_sel_q;
  assign act_bus = act_bus_q;

endmodule

// File: doc/la_ioanalog_muxctrl.md
Name: la_ioanalog_muxctrl

Overview:
- Core-side digital sequencer that routes one of N core analog channels onto one of the two analog IO-ring buses (AMUXBUS_A / AMUXBUS_B). Drives the analog pads' connection direction: core toward ring/pad.
- Enforces break-before-make: every switch enable is low for a programmed gap before a new path closes, followed by a settle window.
- Sits between the core register/control logic and the analog pad switch enables in the IO ring.

Parameters:
- N, 4, number of core analog channels (N >= 2)
- BBM, 4, break-before-make gap in clk cycles with all enables low (BBM >= 1)
- SETTLE, 8, settle window in cycles after the path closes before `settled` asserts (SETTLE >= 1)
- SW, $clog2(N), channel select width (derived; not overridden)
- CW, $clog2(max(BBM,SETTLE)+1), cycle counter width (derived; not overridden)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request strobe
- req_ready  out  1  request accepted when req_valid & req_ready at the rising edge
- req_off  in  1  1 = disconnect everything; 0 = connect req_sel onto req_bus
- req_sel  in  SW  target channel
- req_bus  in  1  0 = bus A, 1 = bus B
- en_a  out  N  per-channel switch enable onto bus A (one-hot or zero)
- en_b  out  N  per-channel switch enable onto bus B (one-hot or zero)
- settled  out  1  path closed and settle window elapsed
- done  out  1  one-cycle pulse when a request completes
- err  out  1  one-cycle pulse when a request with an illegal select is rejected
- act_sel  out  SW  currently connected channel (valid when settled)
- act_bus  out  1  currently connected bus (valid when settled)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset state: IDLE; en_a = en_b = 0; settled, done, err, act_sel, act_bus = 0; counter = 0. Reset mid-sequence drops all enables at the reset edge, with no BBM gap.
- States: IDLE, BREAK, SETTLE, ON.
- All outputs are registered except req_ready, which is combinational: 1 in IDLE and ON, 0 in BREAK and SETTLE.
- At most one bit of en_a | en_b is 1 in any cycle. Enables are 0 in IDLE and BREAK.

Request acceptance (accept edge = k):
- Illegal select (req_off = 0 and req_sel >= N): err = 1 at cycle k+1. No state, enable, or settled change.
- Connect, same path already active (state ON, req_sel == act_sel, req_bus == act_bus): no-op. done = 1 at k+1; enables unchanged; settled stays 1.
- Connect, any other legal case (from IDLE or ON):
  - Enter BREAK at k+1; all enables 0; settled 0; counter = BBM-1.
  - BREAK counts down and lasts exactly BBM cycles.
  - SETTLE begins at k+BBM+1: target enable bit = 1; act_sel/act_bus latched; counter = SETTLE-1.
  - SETTLE lasts exactly SETTLE cycles.
  - ON begins at k+BBM+SETTLE+1 with settled = 1 and done = 1 for that one cycle.
- Off from ON: BREAK for BBM cycles, then IDLE at k+BBM+1 with done = 1 that cycle.
- Off from IDLE: done = 1 at k+1, stays IDLE.
- Requests are ignored while req_ready = 0. req_valid held high is treated as a new request on each ready edge.

Request field capture:
- req_sel, req_bus and req_off are captured at acceptance.
- Input changes during BREAK or SETTLE have no effect.

Test Plan:
(N=4, BBM=4, SETTLE=8)
- Reset, then connect sel=2, bus=0 accepted at edge k:
  - en_a = 0 for cycles k+1..k+4.
  - en_a = 4'b0100 from k+5.
  - settled = 1 and done pulse at k+13.
  - req_ready = 0 for k+1..k+12.
- From ON (ch2/A), connect sel=1, bus=1:
  - en_a and en_b both 0 for exactly 4 cycles.
  - Then en_b = 4'b0010; act_sel = 1, act_bus = 1 when settled.
  - No cycle has two enable bits set.
- From ON, re-request ch1/B: done at k+1, enables unchanged, settled stays 1. Then req_off: enables 0 at k+1, IDLE with done at k+5.
- req_sel = 3'b? illegal: run with N=3 and sel=3 → err pulse at k+1, state and enables unchanged, done stays 0.
- Assert reset during SETTLE (cycle k+7): enables and settled = 0 at the next edge, state IDLE, req_ready = 1.
- Change req_sel/req_bus and pulse req_valid during BREAK: ignored. The final connection matches the originally captured request.
